// File: rtl/eth_fcs_pkg.sv
// Shared types and constants for the Ethernet FCS inserter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_fcs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    // Value left in the MSB-first register after running it over payload plus FCS.
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_fcs_inserter_crc32_step.sv
// One-byte CRC-32 update, MSB-first register with bit-reversed input byte.
// Latency: purely combinational, no register.
// Backpressure: none; the caller decides when the result is captured.
module eth_fcs_inserter_crc32_step
    import eth_fcs_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [7:0]  w_din;
    logic [31:0] w_acc;

    // Shift the byte in bit by bit; reversing first makes bit 0 of the wire byte go in first.
    always_comb begin
        w_din = bitrev8(i_data);
        w_acc = i_crc;
        for (int i = 7; i >= 0; i--) begin
            if (w_acc[31] ^ w_din[i]) begin
                w_acc = {w_acc[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_acc = {w_acc[30:0], 1'b0};
            end
        end
    end

    assign o_crc = w_acc;

endmodule

// File: rtl/eth_fcs_inserter.sv
// Transmit-path FCS inserter: passes payload, zero-pads short frames, appends CRC-32.
// Latency: 1 cycle from input accept to m_valid (single output register).
// Backpressure: s_ready follows m_ready combinationally; deasserted during pad/FCS.
module eth_fcs_inserter
    import eth_fcs_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter bit PAD_EN  = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);

    localparam logic [7:0] MIN_LEN_B = MIN_LEN[7:0];

    state_t           r_state;
    logic [31:0]      r_crc;
    logic [7:0]       r_byte_cnt;
    logic [1:0]       r_fcs_idx;
    logic [7:0]       r_m_data;
    logic             r_m_valid;
    logic             r_m_last;
    logic [CNT_W-1:0] r_frame_count;

    state_t      w_nxt_state;
    logic [31:0] w_nxt_crc;
    logic [7:0]  w_nxt_cnt;
    logic [1:0]  w_nxt_idx;
    logic        w_load;
    logic [7:0]  w_load_data;
    logic        w_load_last;

    logic        w_adv;
    logic        w_accept;
    logic [31:0] w_step_crc_in;
    logic [7:0]  w_step_byte;
    logic [31:0] w_step_crc_out;
    logic [7:0]  w_cnt_inc;
    logic [7:0]  w_cnt_sat;
    logic [7:0]  w_fcs_sel;
    logic [7:0]  w_fcs_byte;

    // The output register may take a new byte when it is empty or being drained.
    assign w_adv    = !r_m_valid || m_ready;
    assign s_ready  = w_adv && ((r_state == IDLE) || (r_state == DATA));
    assign w_accept = s_valid && s_ready;

    // A frame always starts from the init value, so IDLE bypasses the stale register.
    assign w_step_crc_in = (r_state == IDLE) ? CRC_INIT : r_crc;
    assign w_step_byte   = (r_state == PAD) ? 8'h00 : s_data;

    eth_fcs_inserter_crc32_step u_step (
        .i_crc  (w_step_crc_in),
        .i_data (w_step_byte),
        .o_crc  (w_step_crc_out)
    );

    // byte_cnt only has to reach MIN_LEN, so it stops there and long frames never overflow it.
    assign w_cnt_inc = r_byte_cnt + 8'd1;
    assign w_cnt_sat = (r_byte_cnt >= MIN_LEN_B) ? MIN_LEN_B : w_cnt_inc;

    // FCS goes out low byte first; each byte is the complemented, bit-reversed register slice.
    always_comb begin
        w_fcs_sel = r_crc[31:24];
        case (r_fcs_idx)
            2'd0:    w_fcs_sel = r_crc[31:24];
            2'd1:    w_fcs_sel = r_crc[23:16];
            2'd2:    w_fcs_sel = r_crc[15:8];
            default: w_fcs_sel = r_crc[7:0];
        endcase
        w_fcs_byte = ~bitrev8(w_fcs_sel);
    end

    // Next-state, CRC sequencing and output-register load decisions.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_crc   = r_crc;
        w_nxt_cnt   = r_byte_cnt;
        w_nxt_idx   = r_fcs_idx;
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_load_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_load_data = s_data;
                    w_nxt_crc   = w_step_crc_out;
                    w_nxt_cnt   = 8'd1;
                    if (s_last) begin
                        w_nxt_state = (PAD_EN && (8'd1 < MIN_LEN_B)) ? PAD : FCS;
                    end else begin
                        w_nxt_state = DATA;
                    end
                end
            end
            DATA: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_load_data = s_data;
                    w_nxt_crc   = w_step_crc_out;
                    w_nxt_cnt   = w_cnt_sat;
                    if (s_last) begin
                        w_nxt_state = (PAD_EN && (w_cnt_sat < MIN_LEN_B)) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                if (w_adv) begin
                    w_load      = 1'b1;
                    w_load_data = 8'h00;
                    w_nxt_crc   = w_step_crc_out;
                    w_nxt_cnt   = w_cnt_inc;
                    if (w_cnt_inc == MIN_LEN_B) begin
                        w_nxt_state = FCS;
                    end
                end
            end
            FCS: begin
                if (w_adv) begin
                    w_load      = 1'b1;
                    w_load_data = w_fcs_byte;
                    w_nxt_idx   = r_fcs_idx + 2'd1;
                    if (r_fcs_idx == 2'd3) begin
                        w_load_last = 1'b1;
                        w_nxt_idx   = 2'd0;
                        w_nxt_state = IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // Control state and CRC register; synchronous reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_crc      <= CRC_INIT;
            r_byte_cnt <= 8'd0;
            r_fcs_idx  <= 2'd0;
        end else begin
            r_state    <= w_nxt_state;
            r_crc      <= w_nxt_crc;
            r_byte_cnt <= w_nxt_cnt;
            r_fcs_idx  <= w_nxt_idx;
        end
    end

    // Output register: loads only when advancing, so data and last hold during a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= 8'h00;
        end else if (w_load) begin
            r_m_valid <= 1'b1;
            r_m_last  <= w_load_last;
            r_m_data  <= w_load_data;
        end else if (w_adv) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    // Completed-frame counter, stepped by the handshake of the final FCS byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_count <= '0;
        end else if (r_m_valid && m_ready && r_m_last) begin
            r_frame_count <= r_frame_count + CNT_W'(1);
        end
    end

    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign m_last      = r_m_last;
    assign busy        = (r_state != IDLE) || r_m_valid;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_eth_fcs_inserter.sv
// Bench for eth_fcs_inserter: one unpadded instance (4-bit counter) and one padded instance.
// Latency: n/a.
// Backpressure: m_ready held high or randomised per instance.
module tb_eth_fcs_inserter;
    import eth_fcs_pkg::*;

    logic        clk;
    logic        rst       [2];
    logic [7:0]  s_data    [2];
    logic        s_valid   [2];
    logic        s_last    [2];
    logic        s_ready   [2];
    logic [7:0]  m_data    [2];
    logic        m_valid   [2];
    logic        m_last    [2];
    logic        m_ready   [2];
    logic        busy      [2];
    logic [3:0]  fc0;
    logic [15:0] fc1;

    bit          rnd_mode  [2] = '{1'b0, 1'b0};
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  fbuf [0:299];

    // Model state, written only by the compare process.
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    int          tail_left [2] = '{0, 0};
    int          acc_cnt   [2] = '{0, 0};
    logic [31:0] tx_crc    [2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] rx_crc    [2] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    int          exp_fc    [2] = '{0, 0};
    bit          prev_stall[2] = '{1'b0, 1'b0};
    logic [7:0]  prev_dat  [2] = '{8'h00, 8'h00};
    bit          prev_last [2] = '{1'b0, 1'b0};
    int          out_cnt   [2] = '{0, 0};
    int          last_len  [2] = '{0, 0};
    logic [31:0] last4     [2] = '{32'h0, 32'h0};
    logic [31:0] last_resid[2] = '{32'h0, 32'h0};

    eth_fcs_inserter #(.MIN_LEN(60), .PAD_EN(1'b0), .CNT_W(4)) u_nopad (
        .clk(clk), .reset(rst[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
        .s_last(s_last[0]), .s_ready(s_ready[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
        .m_last(m_last[0]), .m_ready(m_ready[0]), .busy(busy[0]), .frame_count(fc0)
    );

    eth_fcs_inserter #(.MIN_LEN(60), .PAD_EN(1'b1), .CNT_W(16)) u_pad (
        .clk(clk), .reset(rst[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
        .s_last(s_last[1]), .s_ready(s_ready[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
        .m_last(m_last[1]), .m_ready(m_ready[1]), .busy(busy[1]), .frame_count(fc1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Standard reflected CRC-32 (LSB-first, 0xEDB88320), independent of the RTL formulation.
    function automatic logic [31:0] crc_refl(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push_exp(input int d, input logic [8:0] v);
        if (d == 0) q0.push_back(v); else q1.push_back(v);
    endfunction

    // Compare process: every cycle, checks outputs against the frame-level model.
    always @(negedge clk) begin
        logic [8:0]  e;
        logic [31:0] f;
        logic [15:0] fcv;
        logic [15:0] fmask;
        bit          adv;
        bit          qempty;
        int          npad;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                if (d == 0) q0.delete(); else q1.delete();
                tail_left[d] = 0; acc_cnt[d] = 0; exp_fc[d] = 0;
                tx_crc[d] = 32'hFFFFFFFF; rx_crc[d] = 32'hFFFFFFFF;
                prev_stall[d] = 1'b0; out_cnt[d] = 0;
            end else begin
                fcv   = (d == 0) ? {12'h0, fc0} : fc1;
                fmask = (d == 0) ? 16'h000F : 16'hFFFF;
                adv   = !m_valid[d] || m_ready[d];
                check(s_ready[d] == ((tail_left[d] == 0) && adv), $sformatf("s_ready d%0d", d),
                      {31'h0, s_ready[d]}, {31'h0, ((tail_left[d] == 0) && adv)});
                check(busy[d] == ((tail_left[d] > 0) || (acc_cnt[d] > 0) || m_valid[d]),
                      $sformatf("busy d%0d", d), {31'h0, busy[d]},
                      {31'h0, ((tail_left[d] > 0) || (acc_cnt[d] > 0) || m_valid[d])});
                check(fcv == 16'(exp_fc[d]), $sformatf("frame_count d%0d", d), {16'h0, fcv},
                      32'(exp_fc[d]));
                if (prev_stall[d]) begin
                    check(m_valid[d] && (m_data[d] == prev_dat[d]) && (m_last[d] == prev_last[d]),
                          $sformatf("stall_hold d%0d", d), {23'h0, m_valid[d], m_data[d]},
                          {23'h0, 1'b1, prev_dat[d]});
                end
                if (m_valid[d] && m_ready[d]) begin
                    qempty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
                    if (qempty) begin
                        check(1'b0, $sformatf("extra_beat d%0d", d), {23'h0, m_last[d], m_data[d]}, 32'h0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check({m_last[d], m_data[d]} == e, $sformatf("out_beat d%0d", d),
                              {23'h0, m_last[d], m_data[d]}, {23'h0, e});
                    end
                    rx_crc[d] = crc_refl(rx_crc[d], m_data[d]);
                    out_cnt[d]++;
                    last4[d] = {last4[d][23:0], m_data[d]};
                    if (m_last[d]) begin
                        last_len[d]   = out_cnt[d];
                        last_resid[d] = rx_crc[d];
                        out_cnt[d]    = 0;
                        rx_crc[d]     = 32'hFFFFFFFF;
                        exp_fc[d]     = int'(16'(exp_fc[d] + 1) & fmask);
                    end
                end
                prev_stall[d] = m_valid[d] && !m_ready[d];
                prev_dat[d]   = m_data[d];
                prev_last[d]  = m_last[d];
                if (adv && (tail_left[d] > 0)) tail_left[d]--;
                if (s_valid[d] && s_ready[d]) begin
                    push_exp(d, {1'b0, s_data[d]});
                    tx_crc[d] = crc_refl(tx_crc[d], s_data[d]);
                    acc_cnt[d]++;
                    if (s_last[d]) begin
                        npad = ((d == 1) && (acc_cnt[d] < 60)) ? (60 - acc_cnt[d]) : 0;
                        for (int k = 0; k < npad; k++) begin
                            push_exp(d, 9'h000);
                            tx_crc[d] = crc_refl(tx_crc[d], 8'h00);
                        end
                        f = ~tx_crc[d];
                        push_exp(d, {1'b0, f[7:0]});
                        push_exp(d, {1'b0, f[15:8]});
                        push_exp(d, {1'b0, f[23:16]});
                        push_exp(d, {1'b1, f[31:24]});
                        tail_left[d] = npad + 4;
                        acc_cnt[d]   = 0;
                        tx_crc[d]    = 32'hFFFFFFFF;
                    end
                end
            end
        end
    end

    // Downstream ready: constant high, or a fair coin per cycle when randomised.
    initial begin
        m_ready[0] = 1'b1;
        m_ready[1] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready[0] = rnd_mode[0] ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready[1] = rnd_mode[1] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int len);
        bit ok;
        int guard;
        for (int i = 0; i < len; i++) begin
            s_valid[d] = 1'b1;
            s_data[d]  = fbuf[i];
            s_last[d]  = (i == len - 1);
            guard = 0;
            do begin
                @(negedge clk);
                ok = s_ready[d];
                tick();
                guard++;
            end while (!ok && guard < 1000);
            if (!ok) check(1'b0, $sformatf("accept_timeout d%0d", d), 32'(i), 32'(len));
        end
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    task automatic drain(input int d);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 3000) begin
            done = !busy[d] && (((d == 0) ? q0.size() : q1.size()) == 0);
            if (!done) tick();
            guard++;
        end
        if (!done) check(1'b0, $sformatf("drain_timeout d%0d", d), 32'(guard), 32'd3000);
    endtask

    task automatic load_digits();
        for (int i = 0; i < 9; i++) fbuf[i] = 8'h31 + 8'(i);
    endtask

    task automatic load_fill(input int len, input logic [7:0] v);
        for (int i = 0; i < len; i++) fbuf[i] = v;
    endtask

    initial begin
        logic [31:0] pin;
        int guard;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; s_valid[d] = 1'b0; s_last[d] = 1'b0; s_data[d] = 8'h00;
        end
        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Reset state of both instances.
        for (int d = 0; d < 2; d++) begin
            check(m_valid[d] == 1'b0, "rst m_valid", {31'h0, m_valid[d]}, 32'h0);
            check(m_last[d] == 1'b0, "rst m_last", {31'h0, m_last[d]}, 32'h0);
            check(m_data[d] == 8'h00, "rst m_data", {24'h0, m_data[d]}, 32'h0);
            check(busy[d] == 1'b0, "rst busy", {31'h0, busy[d]}, 32'h0);
            check(s_ready[d] == 1'b1, "rst s_ready", {31'h0, s_ready[d]}, 32'h1);
        end
        check(fc0 == 4'h0, "rst fc0", {28'h0, fc0}, 32'h0);
        check(fc1 == 16'h0, "rst fc1", {16'h0, fc1}, 32'h0);

        // Pin the reference CRC to the well-known check value.
        pin = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) pin = crc_refl(pin, 8'h31 + 8'(i));
        check(~pin == 32'hCBF43926, "model check value", ~pin, 32'hCBF43926);

        // Abort a frame while FCS byte 2 (0xF4) sits in the output register.
        load_digits();
        send(0, 9);
        guard = 0;
        while (!(m_valid[0] && m_data[0] == 8'hF4) && guard < 20) begin
            tick();
            guard++;
        end
        check(m_data[0] == 8'hF4, "reach fcs2", {24'h0, m_data[0]}, 32'hF4);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check(m_valid[0] == 1'b0, "abort m_valid", {31'h0, m_valid[0]}, 32'h0);
        check(s_ready[0] == 1'b1, "abort s_ready", {31'h0, s_ready[0]}, 32'h1);
        check(fc0 == 4'h0, "abort fc0", {28'h0, fc0}, 32'h0);

        // "123456789" unpadded: 13 bytes ending 26 39 F4 CB.
        send(0, 9);
        drain(0);
        check(last_len[0] == 13, "digits len", 32'(last_len[0]), 32'd13);
        check(last4[0] == 32'h2639F4CB, "digits fcs", last4[0], 32'h2639F4CB);
        check(fc0 == 4'd1, "digits fc0", {28'h0, fc0}, 32'd1);

        // Back-to-back frames under random backpressure.
        rnd_mode[0] = 1'b1;
        for (int n = 0; n < 4; n++) send(0, 9);
        drain(0);
        rnd_mode[0] = 1'b0;
        tick();
        check(last4[0] == 32'h2639F4CB, "b2b fcs", last4[0], 32'h2639F4CB);
        check(fc0 == 4'd5, "b2b fc0", {28'h0, fc0}, 32'd5);

        // Walk the 4-bit counter to its top value, then across the wrap.
        for (int n = 0; n < 10; n++) send(0, 9);
        drain(0);
        check(fc0 == 4'hF, "fc0 max", {28'h0, fc0}, 32'hF);
        send(0, 9);
        drain(0);
        check(fc0 == 4'h0, "fc0 wrap", {28'h0, fc0}, 32'h0);

        // One-byte frame padded to 60, then FCS.
        fbuf[0] = 8'hAA;
        send(1, 1);
        drain(1);
        check(last_len[1] == 64, "pad1 len", 32'(last_len[1]), 32'd64);
        check(bitrev32(last_resid[1]) == CRC_RESIDUE, "pad1 residue", bitrev32(last_resid[1]), CRC_RESIDUE);

        // Exactly MIN_LEN bytes: no pad.
        load_fill(60, 8'h55);
        send(1, 60);
        drain(1);
        check(last_len[1] == 64, "min len", 32'(last_len[1]), 32'd64);
        check(bitrev32(last_resid[1]) == CRC_RESIDUE, "min residue", bitrev32(last_resid[1]), CRC_RESIDUE);

        // One short of MIN_LEN, and a frame beyond 255 bytes, under backpressure.
        rnd_mode[1] = 1'b1;
        for (int i = 0; i < 300; i++) fbuf[i] = 8'(i * 7 + 3);
        send(1, 59);
        drain(1);
        check(last_len[1] == 64, "pad_one len", 32'(last_len[1]), 32'd64);
        send(1, 300);
        drain(1);
        check(last_len[1] == 304, "long len", 32'(last_len[1]), 32'd304);
        check(bitrev32(last_resid[1]) == CRC_RESIDUE, "long residue", bitrev32(last_resid[1]), CRC_RESIDUE);
        rnd_mode[1] = 1'b0;
        tick();
        check(fc1 == 16'd4, "fc1 count", {16'h0, fc1}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
